dequant_unzigzag: RTL



---
 rtl/dequant_unzigzag.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dequant_unzigzag.sv
// dequant_unzigzag: JPEG decode-side dequantizer and inverse zigzag.
// Loads one 8x8 block as a zigzag-ordered coefficient stream, scales each
// coefficient by the Q50 luminance table and stores it in raster order,
// then streams the block out in raster order with a valid/ready handshake.
module dequant_unzigzag #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] coeff_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] B_out,
  output logic [2:0]    B_row,
  output logic [2:0]    B_col,
  output logic          valid,
  input  logic          out_ready,
  output logic          last
);

  // Zigzag index -> raster index.
  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  // Standard luminance quantization table, raster order.
  localparam int QTAB [64] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    k_q, k_d;
  logic [5:0]    r_q, r_d;
  logic [DW-1:0] mem_q [64];

  logic          accept;
  logic          advance;
  logic          wr_en;
  logic [5:0]    wr_idx;
  logic [DW-1:0] wr_data;

  assign in_ready = en & (state_q == LOAD);
  assign accept   = in_ready & in_valid;
  assign advance  = (state_q == DRAIN) & en & out_ready;

  // Write address/data for the coefficient accepted this cycle.
  // Low DW bits of the product are the same for signed or unsigned
  // interpretation, so a plain DW x DW multiply gives the wrapped result.
  always_comb begin
    wr_en   = accept;
    wr_idx  = 6'(ZZ[k_q]);
    wr_data = coeff_in * DW'(QTAB[wr_idx]);
  end

  // Next-state logic: k and r wrap to 0 naturally after index 63.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          k_d = k_q + 6'd1;
          if (k_q == 6'd63) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (advance) begin
          r_d = r_q + 6'd1;
          if (r_q == 6'd63) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      k_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
    end
  end

  // Block buffer; contents need no reset since every block rewrites all 64.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  // Output presentation, forced to zero outside DRAIN.
  always_comb begin
    valid = (state_q == DRAIN);
    B_out = '0;
    B_row = '0;
    B_col = '0;
    last  = 1'b0;
    if (state_q == DRAIN) begin
      B_out = mem_q[r_q];
      B_row = r_q[5:3];
      B_col = r_q[2:0];
      last  = (r_q == 6'd63);
    end
  end

endmodule
